// File: rtl/video_types_pkg.sv
// Shared video types: LCD geometry defaults, 2bpp shade-to-grey mapping, scanout pixel record.
// The grey mapping here is the one the PGM dump uses, so live output and dumps agree.
package video_types;

    localparam int LCD_W_DEF = 160;
    localparam int LCD_H_DEF = 144;

    localparam logic [7:0] GREY_00 = 8'd255;
    localparam logic [7:0] GREY_01 = 8'd170;
    localparam logic [7:0] GREY_10 = 8'd85;
    localparam logic [7:0] GREY_11 = 8'd0;

    typedef struct packed {
        logic [7:0] grey;
        logic       sof;
        logic       eol;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    function automatic logic [7:0] shadeToGrey(input logic [1:0] shade);
        logic [7:0] grey;
        case (shade)
            2'b00:   grey = GREY_00;
            2'b01:   grey = GREY_01;
            2'b10:   grey = GREY_10;
            default: grey = GREY_11;
        endcase
        return grey;
    endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous pixel FIFO; push data visible at the head the cycle after the push.
// No internal backpressure: the producer's credit scheme keeps it from overflowing.
module scanout_fifo
    import video_types::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  pixel_t        push_dat_i,
    input  logic          pop_i,
    output pixel_t        pop_dat_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    pixel_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push_i && full_o));
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));

endmodule

// File: rtl/lcd_scanout.sv
// Raster-order framebuffer reader: 2-cycle latency from first read to first pixel, 1 pixel/cycle.
// Reads are credit-limited by FIFO occupancy plus the read in flight, so pixReady stalls never overflow.
module lcd_scanout
    import video_types::*;
#(
    parameter int LCD_W      = LCD_W_DEF,
    parameter int LCD_H      = LCD_H_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frameStart,
    output logic       busy,
    output logic       fbRdEn,
    output logic [7:0] fbRow,
    output logic [7:0] fbCol,
    input  logic [1:0] fbRdData,
    output logic       pixValid,
    input  logic       pixReady,
    output logic [7:0] pixData,
    output logic       pixSof,
    output logic       pixEol,
    output logic       frameDone
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    scan_state_e   state_q, state_d;
    logic [7:0]    row_q, row_d;
    logic [7:0]    col_q, col_d;
    logic          rd_pend_q;
    logic          tag_sof_q;
    logic          tag_eol_q;

    logic          rd_en;
    logic          last_col;
    logic          last_row;
    logic          credit_ok;
    logic          pop;
    pixel_t        push_dat;
    pixel_t        head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    assign last_col  = (col_q == 8'(LCD_W - 1));
    assign last_row  = (row_q == 8'(LCD_H - 1));
    // Occupancy plus the outstanding read must leave room for the read about to issue.
    assign credit_ok = !fifo_full &&
                       (({1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q}) < (CW + 1)'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frameStart) begin
                    state_d = FETCH;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            FETCH: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 8'd1;
                        end
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                // Leave as the final pixel pops so frameDone lands the cycle after that transfer.
                if (!rd_pend_q &&
                    ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            rd_pend_q <= 1'b0;
            tag_sof_q <= 1'b0;
            tag_eol_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rd_pend_q <= rd_en;
            tag_sof_q <= rd_en && (row_q == '0) && (col_q == '0);
            tag_eol_q <= rd_en && last_col;
        end
    end

    assign push_dat = '{grey: shadeToGrey(fbRdData), sof: tag_sof_q, eol: tag_eol_q};
    assign pop      = pixValid && pixReady;

    scanout_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (rd_pend_q),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign busy      = (state_q == FETCH) || (state_q == DRAIN);
    assign frameDone = (state_q == DONE);
    assign fbRdEn    = rd_en;
    assign fbRow     = row_q;
    assign fbCol     = col_q;
    assign pixValid  = !fifo_empty;
    assign pixData   = fifo_empty ? 8'd0 : head.grey;
    assign pixSof    = !fifo_empty && head.sof;
    assign pixEol    = !fifo_empty && head.eol;

endmodule

// File: tb/tb_lcd_scanout.sv
// Scoreboard bench for lcd_scanout: full 160x144 frames, stalls, ignored starts, mid-frame reset,
// plus a 1x1 instance for the degenerate geometry.
module tb_lcd_scanout;

    localparam int W    = 160;
    localparam int H    = 144;
    localparam int FD   = 4;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frameStart = 1'b0;
    logic       pixReady = 1'b0;
    logic [1:0] fbRdData = 2'b00;
    logic       busy, fbRdEn, pixValid, pixSof, pixEol, frameDone;
    logic [7:0] fbRow, fbCol, pixData;

    logic       b_frameStart = 1'b0;
    logic       b_pixReady = 1'b1;
    logic [1:0] b_fbRdData = 2'b00;
    logic       b_busy, b_fbRdEn, b_pixValid, b_pixSof, b_pixEol, b_frameDone;
    logic [7:0] b_fbRow, b_fbCol, b_pixData;

    lcd_scanout #(.LCD_W(W), .LCD_H(H), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .frameStart(frameStart), .busy(busy),
        .fbRdEn(fbRdEn), .fbRow(fbRow), .fbCol(fbCol), .fbRdData(fbRdData),
        .pixValid(pixValid), .pixReady(pixReady), .pixData(pixData),
        .pixSof(pixSof), .pixEol(pixEol), .frameDone(frameDone)
    );

    lcd_scanout #(.LCD_W(1), .LCD_H(1), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset), .frameStart(b_frameStart), .busy(b_busy),
        .fbRdEn(b_fbRdEn), .fbRow(b_fbRow), .fbCol(b_fbCol), .fbRdData(b_fbRdData),
        .pixValid(b_pixValid), .pixReady(b_pixReady), .pixData(b_pixData),
        .pixSof(b_pixSof), .pixEol(b_pixEol), .frameDone(b_frameDone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    bit pat_sel = 1'b0;

    function automatic logic [1:0] fb_shade(input logic [7:0] r, input logic [7:0] c);
        return pat_sel ? 2'(r + c) : c[1:0];
    endfunction

    function automatic logic [7:0] grey_of(input logic [1:0] s);
        case (s)
            2'd0:    return 8'd255;
            2'd1:    return 8'd170;
            2'd2:    return 8'd85;
            default: return 8'd0;
        endcase
    endfunction

    // Framebuffer model: data for the address presented with fbRdEn appears one cycle later.
    always @(posedge clk) if (fbRdEn) fbRdData <= fb_shade(fbRow, fbCol);
    always @(posedge clk) if (b_fbRdEn) b_fbRdData <= 2'b10;

    logic [9:0] exp_q[$];
    int exp_row, exp_col, outstanding, frame_rd_cnt, xfer_cnt;
    int sof_cnt, eol_cnt, done_cnt, first_rd, first_vld, last_xfer, done_cyc;
    int ready_mode = 0;
    bit stalled = 1'b0;
    logic [10:0] held;

    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       pixReady = 1'b1;
                1:       pixReady = 1'b0;
                default: pixReady = ($urandom_range(0, 9) < 3);
            endcase
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("stall_hold", 32'({pixValid, pixData, pixSof, pixEol}), 32'(held));
                if (fbRdEn) begin
                    check("rd_addr", 32'({fbRow, fbCol}), 32'({exp_row[7:0], exp_col[7:0]}));
                    check("rd_credit", 32'(outstanding < FD), 32'd1);
                    if (first_rd < 0) first_rd = cyc;
                    outstanding++;
                    frame_rd_cnt++;
                    if (exp_col == W - 1) begin
                        exp_col = 0;
                        exp_row = (exp_row == H - 1) ? 0 : exp_row + 1;
                    end else begin
                        exp_col++;
                    end
                end
                if (pixValid && first_vld < 0) first_vld = cyc;
                if (pixValid && pixReady) begin
                    check("sb_avail", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        logic [9:0] e;
                        e = exp_q.pop_front();
                        check("pixel", 32'({pixData, pixSof, pixEol}), 32'(e));
                    end
                    outstanding--;
                    xfer_cnt++;
                    last_xfer = cyc;
                    sof_cnt += int'(pixSof);
                    eol_cnt += int'(pixEol);
                end
                if (frameDone) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_after_xfer", 32'(cyc - last_xfer), 32'd1);
                    check("done_sb_empty", 32'(exp_q.size()), 32'd0);
                end
                stalled = pixValid && !pixReady;
                held    = {pixValid, pixData, pixSof, pixEol};
            end
        end
    end

    task automatic start_frame(input bit accept);
        if (accept) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    exp_q.push_back({grey_of(fb_shade(8'(r), 8'(c))), (r == 0 && c == 0), (c == W - 1)});
                end
            end
            exp_row = 0; exp_col = 0; outstanding = 0; frame_rd_cnt = 0; xfer_cnt = 0;
            sof_cnt = 0; eol_cnt = 0; done_cnt = 0; first_rd = -1; first_vld = -1;
        end
        frameStart = 1'b1;
        @(posedge clk); #1;
        frameStart = 1'b0;
    endtask

    task automatic wait_xfers(input int n, input int bound);
        for (int i = 0; i < bound && xfer_cnt < n; i++) begin
            @(posedge clk); #1;
        end
        check("xfers_reached", 32'(xfer_cnt >= n), 32'd1);
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        check("done_seen", 32'(done_cnt > 0), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        outstanding = 0;
        @(posedge clk); #1;
        check("reset_outputs", 32'({busy, fbRdEn, pixValid, pixSof, pixEol, frameDone, fbRow, fbCol, pixData}), 32'd0);
        reset = 1'b0;
        done_cnt = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({busy, fbRdEn, pixValid, pixSof, pixEol, frameDone, fbRow, fbCol, pixData}), 32'd0);
        check("b_reset_outputs", 32'({b_busy, b_fbRdEn, b_pixValid, b_pixSof, b_pixEol, b_frameDone, b_pixData}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Frame 1: no stalls, a stray start mid-frame and another in the DONE cycle.
        check("idle_busy", 32'(busy), 32'd0);
        start_frame(1'b1);
        check("busy_rise", 32'(busy), 32'd1);
        for (int i = 0; i < NPIX + 200 && !frameDone; i++) begin
            frameStart = (i == 1000);
            @(posedge clk); #1;
        end
        check("f1_done_pulse", 32'(frameDone), 32'd1);
        check("f1_busy_in_done", 32'(busy), 32'd0);
        frameStart = 1'b1;
        @(posedge clk); #1;
        frameStart = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("f1_idle_after", 32'(busy), 32'd0);
        check("f1_reads", 32'(frame_rd_cnt), 32'(NPIX));
        check("f1_pixels", 32'(xfer_cnt), 32'(NPIX));
        check("f1_sof_count", 32'(sof_cnt), 32'd1);
        check("f1_eol_count", 32'(eol_cnt), 32'(H));
        check("f1_done_count", 32'(done_cnt), 32'd1);
        check("f1_latency", 32'(first_vld - first_rd), 32'd2);
        check("f1_throughput", 32'(done_cyc - first_rd), 32'(NPIX + 2));

        // Sink stalled from the start: reads stop at FIFO_DEPTH, then resume in order.
        ready_mode = 1;
        start_frame(1'b1);
        repeat (50) @(posedge clk);
        #1;
        check("stall_reads", 32'(frame_rd_cnt), 32'(FD));
        check("stall_rden", 32'(fbRdEn), 32'd0);
        check("stall_valid", 32'(pixValid), 32'd1);
        ready_mode = 0;
        wait_xfers(100, 1000);
        check("stall_sof_count", 32'(sof_cnt), 32'd1);
        do_reset();

        // Random 30% ready, second pattern, reset at pixel 5000.
        pat_sel = 1'b1;
        ready_mode = 2;
        start_frame(1'b1);
        wait_xfers(5000, 40000);
        do_reset();
        ready_mode = 0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_idle", 32'({busy, pixValid, fbRdEn}), 32'd0);

        // Full frame after the abort.
        start_frame(1'b1);
        wait_done(NPIX + 200);
        repeat (3) @(posedge clk);
        #1;
        check("f2_pixels", 32'(xfer_cnt), 32'(NPIX));
        check("f2_sof_count", 32'(sof_cnt), 32'd1);
        check("f2_eol_count", 32'(eol_cnt), 32'(H));
        check("f2_done_count", 32'(done_cnt), 32'd1);

        // 1x1 geometry.
        b_frameStart = 1'b1;
        @(posedge clk); #1;
        b_frameStart = 1'b0;
        for (int i = 0; i < 20 && !b_pixValid; i++) begin
            @(posedge clk); #1;
        end
        check("b_pixel", 32'({b_pixValid, b_pixData, b_pixSof, b_pixEol}), 32'({1'b1, 8'd85, 1'b1, 1'b1}));
        check("b_done_early", 32'(b_frameDone), 32'd0);
        @(posedge clk); #1;
        check("b_done", 32'({b_frameDone, b_busy, b_pixValid}), 32'b100);
        @(posedge clk); #1;
        check("b_done_once", 32'({b_frameDone, b_busy}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_scanout.md
Name: lcd_scanout

Overview:
- Reader for the LCD framebuffer that the whizgraphics renderer writes.
- After a frame is rendered, walks the 2-bit-per-pixel framebuffer in raster order.
- Maps each shade to an 8-bit grey level, using the same mapping as the PGM dump.
- Streams pixels over a ready/valid interface to a downstream display driver or capture sink.
- Sits between the framebuffer read port and the physical display/video output.

Parameters:
- LCD_W, 160, pixels per line.
- LCD_H, 144, lines per frame.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- frameStart  in  1  one-cycle request to scan out a frame; driven from renderComplete.
- busy  out  1  high from accepted frameStart until frameDone.
- fbRdEn  out  1  framebuffer read strobe.
- fbRow  out  8  framebuffer row address, 0..LCD_H-1.
- fbCol  out  8  framebuffer column address, 0..LCD_W-1.
- fbRdData  in  2  shade at the requested address; valid exactly 1 cycle after fbRdEn.
- pixValid  out  1  pixData is valid.
- pixReady  in  1  sink accepts the pixel.
- pixData  out  8  grey level.
- pixSof  out  1  qualifies pixData as pixel (0,0).
- pixEol  out  1  qualifies pixData as the last pixel of a line (col LCD_W-1).
- frameDone  out  1  one-cycle pulse after the final pixel transfer.

Behaviour:
- Reset:
  - busy, fbRdEn, pixValid, pixSof, pixEol, frameDone all 0.
  - fbRow, fbCol, pixData all 0.
  - FIFO emptied, read counters cleared, FSM forced to IDLE.
  - Reset mid-frame aborts the frame with no frameDone pulse.
  - The read response that lands in the cycle after reset is discarded.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - frameStart=1 moves to FETCH and clears row/col to 0.
  - busy rises the following cycle.
- frameStart while not in IDLE is ignored; there is no queueing.
- FETCH:
  - fbRdEn=1 in any cycle where (FIFO count + reads in flight) < FIFO_DEPTH.
  - fbRow/fbCol hold the address of the read being issued.
  - After each issued read, col increments.
  - At col=LCD_W-1, col wraps to 0 and row increments.
  - Issuing (LCD_H-1, LCD_W-1) moves to DRAIN.
- Read return:
  - The 2-bit value captured 1 cycle after fbRdEn is pushed into the FIFO with its sof and eol tags.
  - Shade-to-grey mapping: 00→255, 01→170, 10→85, 11→0.
  - The credit rule guarantees the FIFO never overflows; a push into a full FIFO is an assertion failure.
- Output:
  - pixValid = FIFO not empty.
  - Transfer occurs when pixValid & pixReady.
  - While pixValid & !pixReady, pixData/pixSof/pixEol hold stable.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pop from empty FIFO is impossible, since pixValid=0 when empty.
- Throughput: with pixReady held at 1, one pixel per cycle after an initial latency of 2 cycles from the first fbRdEn to the first pixValid.
- DRAIN: when the FIFO is empty and nothing is in flight, move to DONE.
- DONE:
  - frameDone=1 for one cycle, then IDLE.
  - busy falls in the same cycle frameDone is asserted.
  - frameStart in the DONE cycle is ignored.
- pixSof is asserted exactly once per frame; pixEol exactly LCD_H times per frame.
- Counter widths:
  - row and col are 8-bit and compare against parameters.
  - Frame pixel count is LCD_W*LCD_H = 23040 and needs 15 bits in the bench.

Decomposition:
- Package video_types: add LCD_W/LCD_H defaults and grey-level constants GREY_00..GREY_11.
- Package video_types: add a shadeToGrey function shared with the PGM writer.
- Package video_types: add a pixel_t struct {grey[7:0], sof, eol}.
- Sub-module scanout_fifo:
  - Parameterized synchronous FIFO of pixel_t.
  - Ports: push, pop, data in/out, count, empty, full.
  - Owns the FIFO_DEPTH storage.
- The FSM, address counters and credit logic stay in lcd_scanout.

Test Plan:
- Framebuffer pattern row r = {00,01,10,11,00,01,10,11,00,01,10,11,...}, pixReady=1, frameStart pulse:
  - 23040 pixels arrive.
  - Line sequence is 255,170,85,0 repeating.
  - pixSof on the first pixel; pixEol every 160th pixel.
  - frameDone exactly once; output matches the PGM dump of the same buffer.
- Random pixReady at 30% high:
  - pixData stable while stalled.
  - No FIFO overflow assertion.
  - fbRdEn never raised when credits are 0.
  - Same pixel sequence as the stall-free run.
- pixReady=0 for 50 cycles after start:
  - Exactly FIFO_DEPTH reads issued, then fbRdEn stays 0.
  - On release, pixels resume in order from (0,0).
- Second frameStart pulsed mid-frame and in the DONE cycle:
  - Both ignored.
  - A single frameDone; a new start in IDLE produces a complete second frame.
- Reset asserted at pixel 5000:
  - Next cycle all outputs 0 and FIFO empty.
  - No frameDone.
  - A subsequent frameStart produces a full frame beginning with pixSof at (0,0).
- Degenerate dimensions LCD_W=1, LCD_H=1:
  - One pixel with pixSof=pixEol=1.
  - frameDone one cycle after the transfer.
